mc_inject_ni: RTL and testbench
===============================

Name: mc_inject_ni

Overview:
- Network-interface injector for the multicast router: the transmit end that builds multicast flits for the route-computation stage.
- Accepts local injection requests (16-bit destination bitmap plus 8-bit payload) and buffers them in a DEPTH-entry FIFO.
- Formats each request into a DATASIZE-bit multicast flit and presents it on a registered valid/ready output toward the router input port.
- Drops requests whose sanitised destination bitmap is empty and counts them.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two.
- WIDTH, 2, FIFO pointer width; equals log2(DEPTH).
- DATASIZE, 30, flit width; the format below is defined for 30 only.
- router_ID, 6, source router ID, placed in flit bits [29:25]; 5 bits.

Ports:
- rc_clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  injection request valid.
- req_ready  output  1  FIFO can accept a request.
- req_dst  input  16  destination bitmap: [3:0] S group, [4] L (local), [7:5] reserved, [15:8] E group.
- req_payload  input  8  payload byte.
- data_out  output  DATASIZE  flit to the router.
- valid_out  output  1  data_out holds a valid flit.
- out_ready  input  1  router accepts the flit this cycle.
- fifo_count  output  WIDTH+1  current FIFO occupancy, 0..DEPTH.
- drop_cnt  output  8  saturating count of dropped requests.

Behaviour:
- Reset: rst_n low at a rising edge clears everything. After that edge: valid_out=0, data_out=0, fifo_count=0, drop_cnt=0, read and write pointers=0, FSM=EMPTY. Reset takes priority over every other event, including a transfer in flight; an in-flight flit is discarded.
- Sanitise: dst_s = req_dst with bits [7:5] forced to 0.
- Flit format: {router_ID[4:0], dst_s[15:0], req_payload[7:0], 1'b1}. Bits are [29:25] source, [24:9] destination list, [8:1] payload, [0]=1 flit-valid flag.
- req_ready = (fifo_count < DEPTH). It is combinational from registered state only and does not depend on a same-cycle pop.
- Accept event: req_valid && req_ready at a rising edge.
  - dst_s != 0: write the formatted flit at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - dst_s == 0: no write; drop_cnt increments and saturates at 255.
- Output FSM, two states:
  - EMPTY (valid_out=0): if the FIFO is non-empty, pop the head into data_out, set valid_out=1, go to FULL.
  - FULL (valid_out=1):
    - out_ready=0: data_out and valid_out stay stable.
    - out_ready=1 and FIFO non-empty: pop the next entry into data_out in the same edge; stay FULL. This gives back-to-back, one flit per cycle.
    - out_ready=1 and FIFO empty: valid_out=0, go to EMPTY. data_out keeps its last value.
- No FIFO bypass. Minimum latency: accepted at edge N, written to the FIFO; valid_out=1 with the flit after edge N+1.
- Simultaneous push and pop in one edge: fifo_count is unchanged and both pointers advance. A push into a full FIFO cannot occur, because req_ready=0 when full.
- fifo_count counts FIFO entries only; the flit held in the output register is excluded.
- Total storage is DEPTH+1 flits.
- FIFO order is strict FIFO, and every pointer wraps cleanly through DEPTH.

Test Plan:
- Reset then idle: drive rst_n=0 for 2 edges then release -> valid_out=0, data_out=0, fifo_count=0, drop_cnt=0, req_ready=1.
- Single inject: req_dst=16'h0113, payload=8'hA5, out_ready=1 -> after edge N+1, valid_out=1 and data_out={5'd6,16'h0113,8'hA5,1'b1}; it is consumed on the next edge, then valid_out=0.
- Reserved clear and drop:
  - req_dst=16'h00E0 -> drop_cnt=1, no flit emitted.
  - req_dst=16'h00F1 -> flit carries dst 16'h0011.
  - 300 zero-dst requests -> drop_cnt=255.
- Backpressure fill: out_ready=0, inject 6 requests -> 5 accepted (1 held in the output register, 4 in the FIFO), req_ready=0 with fifo_count=4, data_out stable. Then out_ready=1 -> 5 flits in order, one per cycle, back-to-back.
- Wrap and simultaneous push/pop: stream 20 requests with out_ready=1 every cycle -> 20 flits in order, fifo_count never exceeds 1, pointers wrap 5 times.
- Reset mid-stream: assert rst_n=0 while valid_out=1, out_ready=0, fifo_count=3 -> after the edge, all outputs are 0 and no stale flit appears after reset is released.

Source files
------------

// File: rtl/mc_inject_ni.sv
// rtl/mc_inject_ni.sv - multicast network-interface injector: request FIFO, flit formatter, registered output
module mc_inject_ni #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 2,
    parameter int DATASIZE  = 30,
    parameter int router_ID = 6
) (
    input  logic                rc_clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [15:0]         req_dst,
    input  logic [7:0]          req_payload,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                out_ready,
    output logic [WIDTH:0]      fifo_count,
    output logic [7:0]          drop_cnt
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    localparam logic [4:0]     SRC_ID  = 5'(router_ID);
    localparam logic [WIDTH:0] DEPTH_V = (WIDTH+1)'(DEPTH);

    state_t                state_q, state_d;
    logic [DATASIZE-1:0]   mem [DEPTH];
    logic [WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]        count_q, count_d;
    logic [7:0]            drop_q, drop_d;
    logic [DATASIZE-1:0]   data_q, data_d;

    logic [15:0]           dst_s;
    logic [DATASIZE-1:0]   flit;
    logic                  accept, push, drop, pop, fifo_empty;

    // Reserved destination bits [7:5] never reach the router.
    assign dst_s      = req_dst & 16'hFF1F;
    assign flit       = {SRC_ID, dst_s, req_payload, 1'b1};
    assign req_ready  = (count_q < DEPTH_V);
    assign accept     = req_valid && req_ready;
    assign push       = accept && (dst_s != 16'h0000);
    assign drop       = accept && (dst_s == 16'h0000);
    assign fifo_empty = (count_q == '0);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        data_d   = pop  ? mem[rd_ptr_q]          : data_q;
        rd_ptr_d = pop  ? rd_ptr_q + WIDTH'(1)   : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + WIDTH'(1)   : wr_ptr_q;
        count_d  = count_q + (WIDTH+1)'(push) - (WIDTH+1)'(pop);
        drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge rc_clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge rc_clk) begin
        if (push) mem[wr_ptr_q] <= flit;
    end

    assign data_out   = data_q;
    assign valid_out  = (state_q == ST_FULL);
    assign fifo_count = count_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_mc_inject_ni.sv
// tb/tb_mc_inject_ni.sv - randomized and directed bench for mc_inject_ni against a queue reference model
module tb_mc_inject_ni;

    logic        rc_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_dst = '0;
    logic [7:0]  req_payload = '0;
    logic [29:0] data_out;
    logic        valid_out;
    logic        out_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int consumed = 0;

    logic [29:0] fq[$];
    logic        mv;
    logic [29:0] md;
    int          mdrop;

    mc_inject_ni dut (
        .rc_clk      (rc_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dst     (req_dst),
        .req_payload (req_payload),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .drop_cnt    (drop_cnt)
    );

    always #5 rc_clk = ~rc_clk;

    function automatic logic [29:0] mk(input logic [15:0] d, input logic [7:0] p);
        logic [15:0] ds;
        ds = d & 16'hFF1F;
        return {5'd6, ds, p, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            fq.delete();
            mv    = 1'b0;
            md    = '0;
            mdrop = 0;
        end else begin
            acc = req_valid && (fq.size() < 4);
            if (fq.size() > 0 && (!mv || out_ready)) begin
                md = fq.pop_front();
                mv = 1'b1;
            end else if (mv && out_ready) begin
                mv = 1'b0;
            end
            if (acc) begin
                if ((req_dst & 16'hFF1F) != 16'h0000) fq.push_back(mk(req_dst, req_payload));
                else if (mdrop < 255) mdrop++;
            end
        end
    endtask

    task automatic step();
        if (valid_out === 1'b1 && out_ready) consumed++;
        @(posedge rc_clk);
        model_edge();
        @(negedge rc_clk);
        chk("valid_out",  32'(valid_out),  32'(mv));
        chk("data_out",   32'(data_out),   32'(md));
        chk("fifo_count", 32'(fifo_count), 32'(fq.size()));
        chk("drop_cnt",   32'(drop_cnt),   32'(mdrop));
        chk("req_ready",  32'(req_ready),  32'(fq.size() < 4));
    endtask

    function automatic logic [15:0] rand_dst();
        logic [15:0] d;
        d = 16'($urandom);
        if ((d & 16'hFF1F) == 16'h0000) d[8] = 1'b1;
        return d;
    endfunction

    initial begin
        mv = 1'b0; md = '0; mdrop = 0;

        // Reset then idle
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data",  32'(data_out),  32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Single inject: minimum latency is two edges
        out_ready = 1'b1; req_valid = 1'b1; req_dst = 16'h0113; req_payload = 8'hA5;
        step();
        req_valid = 1'b0;
        chk("single_not_yet", 32'(valid_out), 32'd0);
        step();
        chk("single_valid", 32'(valid_out), 32'd1);
        chk("single_data",  32'(data_out),  32'({5'd6, 16'h0113, 8'hA5, 1'b1}));
        step();
        chk("single_consumed", 32'(valid_out), 32'd0);

        // Reserved-only destination is dropped
        req_valid = 1'b1; req_dst = 16'h00E0; req_payload = 8'h11;
        step();
        req_valid = 1'b0;
        step(); step();
        chk("drop_one", 32'(drop_cnt), 32'd1);
        chk("drop_no_flit", 32'(valid_out), 32'd0);

        // Reserved bits stripped
        req_valid = 1'b1; req_dst = 16'h00F1; req_payload = 8'h3C;
        step();
        req_valid = 1'b0;
        step();
        chk("sanit_dst", 32'(data_out[24:9]), 32'h0011);
        step();

        // Drop counter saturates
        req_valid = 1'b1; req_dst = 16'h0000;
        for (int i = 0; i < 300; i++) step();
        req_valid = 1'b0;
        step();
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Backpressure fill: 5 of 6 accepted
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_dst = rand_dst(); req_payload = 8'($urandom);
            step();
        end
        req_valid = 1'b0;
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_ready", 32'(req_ready), 32'd0);
        chk("fill_valid", 32'(valid_out), 32'd1);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("fill_drained", 32'(valid_out), 32'd0);

        // Streaming with simultaneous push/pop, pointers wrap
        consumed = 0;
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1; req_dst = rand_dst(); req_payload = 8'($urandom);
            step();
            chk("stream_cnt_le1", 32'(fifo_count <= 3'd1), 32'd1);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("stream_consumed", 32'(consumed), 32'd20);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            req_dst     = ($urandom_range(0, 7) == 0) ? 16'($urandom & 32'h00E0) : rand_dst();
            req_payload = 8'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            step();
        end
        req_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Reset mid-stream discards everything
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_dst = rand_dst(); req_payload = 8'($urandom);
            step();
        end
        req_valid = 1'b0;
        chk("mid_valid", 32'(valid_out), 32'd1);
        chk("mid_count", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        step();
        chk("mrst_valid", 32'(valid_out), 32'd0);
        chk("mrst_data",  32'(data_out),  32'd0);
        chk("mrst_count", 32'(fifo_count), 32'd0);
        chk("mrst_drop",  32'(drop_cnt),  32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_idle", 32'(valid_out), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
